// File: rtl/everloop_rx_if.sv
// Everloop receive-side signal bundle: serial line and enable in, decoded word and status pulses out.
// Latency: none, wires only.
// Backpressure: none; the pulses are fire-and-forget and the consumer must sample them every cycle.
// Ports: everloop_in, enable (to decoder); data_out, data_valid, frame_end, bit_error, rx_busy (from decoder).
interface everloop_rx_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  everloop_in;
  logic                  enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  frame_end;
  logic                  bit_error;
  logic                  rx_busy;

  // master drives the line and enable, and observes the decoder.
  modport master (
    output everloop_in, enable,
    input  data_out, data_valid, frame_end, bit_error, rx_busy
  );

  // slave is the decoder itself.
  modport slave (
    input  everloop_in, enable,
    output data_out, data_valid, frame_end, bit_error, rx_busy
  );
endinterface

// File: rtl/everloop_rx.sv
// Everloop pulse-width decoder: high width encodes the bit (MSB first), a long low gap ends the frame.
// Latency: outputs pulse on the 3rd rising clk edge after a line transition is first sampled.
// Backpressure: none; data_valid/frame_end/bit_error are single-cycle pulses that are never held.
// Ports: clk, resetn (async, active-high), bus (everloop_rx_if.slave: everloop_in, enable in;
//        data_out, data_valid, frame_end, bit_error, rx_busy out).
// SYS_FREQ_HZ must be set by every instance to the real clk frequency.
module everloop_rx #(
  parameter longint unsigned SYS_FREQ_HZ  = 100_000_000,
  parameter int              DATA_WIDTH   = 24,
  parameter int              THRESHOLD_NS = 450,
  parameter int              MIN_HIGH_NS  = 100,
  parameter int              MAX_HIGH_NS  = 1000,
  parameter int              RESET_LOW_NS = 50000,
  parameter int              CNT_WIDTH    = 16
) (
  input logic         clk,
  input logic         resetn,
  everloop_rx_if.slave bus
);

  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;
  localparam longint unsigned THRESH_L = (SYS_FREQ_HZ * 64'(THRESHOLD_NS) + NS_PER_S - 1) / NS_PER_S;
  localparam longint unsigned MIN_L    = (SYS_FREQ_HZ * 64'(MIN_HIGH_NS)  + NS_PER_S - 1) / NS_PER_S;
  localparam longint unsigned MAX_L    = (SYS_FREQ_HZ * 64'(MAX_HIGH_NS)  + NS_PER_S - 1) / NS_PER_S;
  localparam longint unsigned RESET_L  = (SYS_FREQ_HZ * 64'(RESET_LOW_NS) + NS_PER_S - 1) / NS_PER_S;

  localparam logic [CNT_WIDTH-1:0] THRESH_CNT = CNT_WIDTH'(THRESH_L);
  localparam logic [CNT_WIDTH-1:0] MIN_CNT    = CNT_WIDTH'(MIN_L);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT    = CNT_WIDTH'(MAX_L);
  localparam logic [CNT_WIDTH-1:0] RESET_CNT  = CNT_WIDTH'(RESET_L);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t                state;
  logic                  s1, s2, s3;
  logic [CNT_WIDTH-1:0]  high_cnt, low_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q, frame_end_q, bit_error_q, rx_busy_q;

  logic                  rise, fall;
  logic [CNT_WIDTH-1:0]  high_len, low_len;
  logic                  new_bit;
  logic [DATA_WIDTH-1:0] shifted;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // The counters clear on the entry edge, but the cycle in which the edge is
  // seen on s2 is already the first cycle of the level. The measured length
  // is therefore count + 1, saturating, and that is also the next count.
  assign high_len = (&high_cnt) ? high_cnt : high_cnt + CNT_WIDTH'(1);
  assign low_len  = (&low_cnt)  ? low_cnt  : low_cnt  + CNT_WIDTH'(1);

  assign new_bit = (high_len >= THRESH_CNT);
  assign shifted = {shreg[DATA_WIDTH-2:0], new_bit};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      high_cnt     <= '0;
      low_cnt      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      bit_error_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      s1 <= bus.everloop_in;
      s2 <= s1;
      s3 <= s2;

      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      bit_error_q  <= 1'b0;

      if (!bus.enable) begin
        state     <= IDLE;
        high_cnt  <= '0;
        low_cnt   <= '0;
        shreg     <= '0;
        bit_cnt   <= '0;
        rx_busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state     <= HIGH;
              high_cnt  <= '0;
              rx_busy_q <= 1'b1;
            end
          end

          HIGH: begin
            high_cnt <= high_len;
            // A fall takes precedence over reaching MAX, so a pulse of
            // exactly MAX cycles still decodes as a bit.
            if (fall) begin
              state <= LOW;
              if (high_len >= MIN_CNT) begin
                low_cnt <= '0;
                shreg   <= shifted;
                if (bit_cnt == LAST_BIT) begin
                  data_out_q   <= shifted;
                  data_valid_q <= 1'b1;
                  bit_cnt      <= '0;
                end else begin
                  bit_cnt <= bit_cnt + BC_W'(1);
                end
              end
              // Otherwise a glitch: the low gap resumes where it left off.
            end else if (high_len >= MAX_CNT) begin
              state       <= STUCK;
              bit_error_q <= 1'b1;
              shreg       <= '0;
              bit_cnt     <= '0;
            end
          end

          STUCK: begin
            if (fall) begin
              state   <= LOW;
              low_cnt <= '0;
            end
          end

          LOW: begin
            // A rise wins over the gap timer expiring in the same cycle.
            if (rise) begin
              state    <= HIGH;
              high_cnt <= '0;
            end else if (low_len >= RESET_CNT) begin
              state       <= IDLE;
              rx_busy_q   <= 1'b0;
              frame_end_q <= 1'b1;
              low_cnt     <= '0;
              if (bit_cnt != '0) begin
                bit_error_q <= 1'b1;
                bit_cnt     <= '0;
                shreg       <= '0;
              end
            end else begin
              low_cnt <= low_len;
            end
          end

          default: begin
            state     <= IDLE;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.bit_error  = bit_error_q;
  assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_everloop_rx.sv
// Bench for everloop_rx at 100 MHz: directed pulse trains with a scoreboard of expected output events.
// Latency: events are matched in order, independent of exact cycle.
// Backpressure: none; every data_valid/frame_end/bit_error cycle is popped against the queue.
module tb_everloop_rx;

  typedef struct packed {
    logic        dv;
    logic        fe;
    logic        be;
    logic [23:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  obs_ev, exp_ev;

  always #5 clk = ~clk;

  everloop_rx_if #(.DATA_WIDTH(24)) bus ();

  everloop_rx #(
    .SYS_FREQ_HZ (100_000_000),
    .DATA_WIDTH  (24)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Every cycle with any output pulse must match the next expected event.
  always @(negedge clk) begin
    if (bus.data_valid || bus.frame_end || bus.bit_error) begin
      obs_ev = '{dv: bus.data_valid, fe: bus.frame_end, be: bus.bit_error,
                 data: bus.data_valid ? bus.data_out : 24'h0};
      exp_ev = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'('0);
      checks++;
      assert (obs_ev === exp_ev) else begin
        errors++;
        $error("FAIL event: got dv=%0b fe=%0b be=%0b data=%h, expected dv=%0b fe=%0b be=%0b data=%h",
               obs_ev.dv, obs_ev.fe, obs_ev.be, obs_ev.data,
               exp_ev.dv, exp_ev.fe, exp_ev.be, exp_ev.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_data(input logic [23:0] d);
    exp_q.push_back('{dv: 1'b1, fe: 1'b0, be: 1'b0, data: d});
  endtask

  task automatic push_ev(input logic fe, input logic be);
    exp_q.push_back('{dv: 1'b0, fe: fe, be: be, data: 24'h0});
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.everloop_in = 1'b1;
    tick(hi);
    bus.everloop_in = 1'b0;
    tick(lo);
  endtask

  // 1.25 us bit period: 0 = 300 ns high, 1 = 600 ns high.
  task automatic send_bit(input logic b);
    if (b) pulse(60, 65);
    else   pulse(30, 95);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    tick(5100);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_out"},   bus.data_out, 24'h0);
    check({tag, " data_valid"}, 24'(bus.data_valid), 24'h0);
    check({tag, " frame_end"},  24'(bus.frame_end), 24'h0);
    check({tag, " bit_error"},  24'(bus.bit_error), 24'h0);
    check({tag, " rx_busy"},    24'(bus.rx_busy), 24'h0);
  endtask

  initial begin
    bus.everloop_in = 1'b0;
    bus.enable      = 1'b1;
    resetn          = 1'b1;
    tick(3);
    check_all_zero("reset");
    resetn = 1'b0;
    tick(2);

    // Single word then a long gap.
    push_data(24'hA5C33C);
    push_ev(1'b1, 1'b0);
    send_word(24'hA5C33C);
    check("busy_in_frame", 24'(bus.rx_busy), 24'h1);
    gap();
    check("t1 data_out", bus.data_out, 24'hA5C33C);
    check("t1 idle", 24'(bus.rx_busy), 24'h0);

    // Back-to-back words, one frame end.
    push_data(24'h000001);
    push_data(24'hFFFFFE);
    push_ev(1'b1, 1'b0);
    send_word(24'h000001);
    send_word(24'hFFFFFE);
    gap();
    check("t2 data_out", bus.data_out, 24'hFFFFFE);

    // Threshold boundary 44/45 clk, second word with a 50 ns spike in each low.
    push_data(24'h555555);
    push_data(24'h555555);
    push_ev(1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 1) pulse(45, 80);
      else            pulse(44, 81);
    end
    for (int i = 0; i < 24; i++) begin
      int hi;
      hi = (i % 2 == 1) ? 45 : 44;
      bus.everloop_in = 1'b1;
      tick(hi);
      bus.everloop_in = 1'b0;
      tick(30);
      pulse(5, 125 - hi - 35);
    end
    gap();
    check("t3 data_out", bus.data_out, 24'h555555);

    // Stuck-high after 5 bits, then a clean word.
    push_ev(1'b0, 1'b1);
    push_data(24'h3C3C3C);
    push_ev(1'b1, 1'b0);
    send_bits(24'hB00000, 5);
    pulse(120, 100);
    check("t4 no word yet", bus.data_out, 24'h555555);
    send_word(24'h3C3C3C);
    gap();
    check("t4 data_out", bus.data_out, 24'h3C3C3C);

    // Partial word at frame end: frame_end and bit_error together.
    push_ev(1'b1, 1'b1);
    send_bits(24'hABC000, 10);
    gap();
    check("t5 data_out kept", bus.data_out, 24'h3C3C3C);
    check("t5 idle", 24'(bus.rx_busy), 24'h0);

    // Reset mid-word.
    send_bits(24'hFEDCBA, 12);
    check("t6 busy mid-word", 24'(bus.rx_busy), 24'h1);
    tick(20);
    resetn = 1'b1;
    tick(3);
    check_all_zero("t6 in reset");
    resetn = 1'b0;
    tick(2);
    push_data(24'h123456);
    push_ev(1'b1, 1'b0);
    send_word(24'h123456);
    gap();
    check("t6 data_out", bus.data_out, 24'h123456);

    // Enable dropped mid-word.
    send_bits(24'h987654, 12);
    tick(20);
    bus.enable = 1'b0;
    tick(3);
    check("t6b busy off", 24'(bus.rx_busy), 24'h0);
    check("t6b data_out kept", bus.data_out, 24'h123456);
    bus.enable = 1'b1;
    tick(2);
    push_data(24'h0F1E2D);
    push_ev(1'b1, 1'b0);
    send_word(24'h0F1E2D);
    gap();
    check("t6b data_out", bus.data_out, 24'h0F1E2D);

    check("events outstanding", 24'(exp_q.size()), 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/everloop_rx.md
Name: everloop_rx

Overview:
- Single-wire pulse-width decoder for the Everloop LED protocol: high-pulse width encodes the bit, a long low gap ends the frame.
- Samples the DOUT of the last LED in the ring, fed back through a spare FPGA pin.
- Reassembles DATA_WIDTH-bit words, MSB first, and flags timing errors.
- Used for chain-integrity loopback checks and bring-up diagnostics; sits beside the Everloop transmitter on the wishbone Everloop peripheral.

Parameters:
SYS_FREQ_HZ, mandatory, system clock frequency in Hz
DATA_WIDTH, 24, bits per word (one LED colour word)
THRESHOLD_NS, 450, high time at or above this decodes as 1, below as 0
MIN_HIGH_NS, 100, shorter high pulses are glitches and ignored
MAX_HIGH_NS, 1000, high time reaching this is a stuck-high error
RESET_LOW_NS, 50000, low time reaching this ends the frame
CNT_WIDTH, 16, width of the high and low counters (saturating)
Derived counts (all integer, rounded up): X_CNT = ceil(SYS_FREQ_HZ*X_NS/1e9) for THRESH_CNT, MIN_CNT, MAX_CNT, RESET_CNT.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous reset, active-high
everloop_in  input  1  asynchronous serial line from the LED chain
enable  input  1  decoder enable; low holds the FSM in IDLE
data_out  output  DATA_WIDTH  last complete word, MSB = first received bit
data_valid  output  1  one-cycle pulse when data_out is updated
frame_end  output  1  one-cycle pulse when the reset gap is detected
bit_error  output  1  one-cycle pulse on stuck-high or partial-word-at-frame-end
rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (resetn high, asynchronous):
  - All outputs go to 0, including data_out.
  - Sync flops, counters, shift register, bit_cnt and the FSM (IDLE) are cleared.
  - A reset mid-word discards the word and produces no pulses.
- Input path:
  - 2-flop synchronizer (s1, s2) plus a registered copy s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The FSM acts on the clock edge after the edge is visible on s2.
  - Result: outputs assert on the 3rd rising clk edge after the pin transition is first sampled.
- high_cnt and low_cnt:
  - Clear to 0 on entering HIGH and LOW respectively.
  - Increment each cycle in their state and saturate at all-ones.
- FSM states:
  - IDLE: line is low and no word is in progress. On rise, enter HIGH.
  - HIGH: on fall, with high_cnt < MIN_CNT, treat the pulse as a glitch. Return to LOW, bit_cnt unchanged, low_cnt not cleared, no bit shifted.
  - HIGH: on fall, with MIN_CNT <= high_cnt < MAX_CNT, decode bit = (high_cnt >= THRESH_CNT). Shift it into the LSB of shreg, increment bit_cnt, enter LOW.
  - HIGH: if high_cnt reaches MAX_CNT while still high, pulse bit_error, clear shreg and bit_cnt, enter STUCK.
  - STUCK: on fall, enter LOW. No further bit_error for the same pulse.
  - LOW: on rise, enter HIGH.
  - LOW: if low_cnt reaches RESET_CNT, pulse frame_end and enter IDLE. If bit_cnt != 0 at that moment, also pulse bit_error in the same cycle and clear the partial word.
- Word completion:
  - When the shifted bit is number DATA_WIDTH, data_out <= {shreg[DATA_WIDTH-2:0], bit}.
  - data_valid pulses for exactly 1 cycle and bit_cnt returns to 0.
  - Back-to-back words need no gap.
- Priority:
  - In LOW, a rise in the same cycle that low_cnt reaches RESET_CNT takes priority: no frame_end.
  - In HIGH, a fall in the same cycle that high_cnt reaches MAX_CNT decodes as a normal bit.
- IDLE after reset: a line that is low with no activity never produces frame_end. The frame_end timer only runs in LOW.
- enable low:
  - Forces IDLE and clears counters, shreg and bit_cnt on the next edge.
  - data_out retains its value. No pulses are generated.
  - A partial word is discarded silently.
- data_out changes only on a data_valid cycle.
- rx_busy = (state != IDLE), registered.

Test Plan:
All cases use SYS_FREQ_HZ=100_000_000 and defaults, giving THRESH=45, MIN=10, MAX=100, RESET=5000 clk. Bits are sent with 1.25us period: 0 = 300ns high, 1 = 600ns high.
1. Send 0xA5C33C, then 60us low -> one data_valid with data_out=0xA5C33C, then one frame_end, bit_error never asserted.
2. Send two words 0x000001 and 0xFFFFFE back to back, then a gap -> data_valid twice with values in order, single frame_end.
3. Boundary: 24 bits alternating 44-clk and 45-clk highs -> data_out=0x555555. Insert a 50ns spike mid-low -> ignored, same result.
4. Hold line high 1.2us after 5 bits -> bit_error once at 100 clk of high; next full word decodes correctly, no data_valid for the aborted word.
5. Send 10 bits, then 60us low -> frame_end and bit_error in the same cycle, data_out unchanged, no data_valid.
6. Assert resetn mid-word (bit 12), then send a fresh full word -> all outputs 0 during reset; only the fresh word appears, with a single data_valid. Repeat the scenario with enable dropped mid-word instead of reset -> partial word discarded, data_out keeps its previous value.
